// File: rtl/wb_store_buffer_ctrl.sv
// ---------------------------------------------------------------------------
// wb_store_buffer_ctrl
//
// Store buffer that sits between the writeback stage's dcache write outputs
// and the dcache write port. Validated WB stores are queued in program order
// and drained one at a time under the dcache In_write_ready handshake. WB is
// only stalled when the queue is full or a drain (flush) is in progress.
// Loads are checked against pending stores on 8-byte granules.
//
// Ports
//   CLK             clock, all state updates on the rising edge
//   CLR             asynchronous active-high reset
//   SB_enq_v        validated store from WB
//   SB_enq_addr     store address
//   SB_enq_data     store data
//   SB_enq_size     store size (00 byte, 01 word, 10 dword, 11 qword)
//   In_write_ready  dcache accepts the presented write this cycle
//   LD_check_v      load lookup valid
//   LD_check_addr   load address
//   SB_flush_req    one-cycle pulse requesting a full drain
//   DC_write_req    head entry valid and presented to the dcache
//   DC_write_addr   head address (0 when empty)
//   DC_write_data   head data (0 when empty)
//   DC_write_size   head size (0 when empty)
//   sb_stall        WB must hold its store this cycle
//   sb_empty        no valid entries
//   ld_conflict     load overlaps a pending (or same-cycle accepted) store
//   sb_flush_done   one-cycle pulse when a requested drain completes
// ---------------------------------------------------------------------------
module wb_store_buffer_ctrl #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic        CLK,
    input  logic        CLR,
    input  logic        SB_enq_v,
    input  logic [31:0] SB_enq_addr,
    input  logic [63:0] SB_enq_data,
    input  logic [1:0]  SB_enq_size,
    input  logic        In_write_ready,
    input  logic        LD_check_v,
    input  logic [31:0] LD_check_addr,
    input  logic        SB_flush_req,
    output logic        DC_write_req,
    output logic [31:0] DC_write_addr,
    output logic [63:0] DC_write_data,
    output logic [1:0]  DC_write_size,
    output logic        sb_stall,
    output logic        sb_empty,
    output logic        ld_conflict,
    output logic        sb_flush_done
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_FLUSH = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam logic [PTR_W:0]   LP_FULL_CNT = DEPTH[PTR_W:0];
    localparam logic [PTR_W:0]   LP_CNT_ONE  = {{PTR_W{1'b0}}, 1'b1};
    localparam logic [PTR_W-1:0] LP_PTR_ONE  = {{(PTR_W-1){1'b0}}, 1'b1};

    logic [31:0]    r_addr  [DEPTH];
    logic [63:0]    r_data  [DEPTH];
    logic [1:0]     r_size  [DEPTH];
    logic [DEPTH-1:0] r_valid;
    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_tail;
    logic [PTR_W:0]   r_count;
    state_t         r_state;
    state_t         w_state_next;

    logic w_full;
    logic w_empty;
    logic w_enq;
    logic w_deq;
    logic w_entry_hit;
    logic w_unused_low_bits;

    // Full and empty come straight from the registered count, so a dequeue
    // in the same cycle never frees a slot for an enqueue while full.
    assign w_full  = (r_count == LP_FULL_CNT);
    assign w_empty = (r_count == '0);

    assign w_enq = SB_enq_v & ~w_full & (r_state == ST_RUN);
    assign w_deq = ~w_empty & In_write_ready;

    // Queue storage and pointers. The pointers are exactly log2(DEPTH) bits
    // wide, so incrementing past DEPTH-1 wraps to 0 on its own. Enqueue and
    // dequeue never touch the same slot in one cycle: equal pointers with
    // entries present means full, which blocks the enqueue.
    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_valid <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_addr[i] <= '0;
                r_data[i] <= '0;
                r_size[i] <= '0;
            end
        end else begin
            if (w_deq) begin
                r_valid[r_head] <= 1'b0;
                r_head          <= r_head + LP_PTR_ONE;
            end
            if (w_enq) begin
                r_valid[r_tail] <= 1'b1;
                r_addr[r_tail]  <= SB_enq_addr;
                r_data[r_tail]  <= SB_enq_data;
                r_size[r_tail]  <= SB_enq_size;
                r_tail          <= r_tail + LP_PTR_ONE;
            end
            case ({w_enq, w_deq})
                2'b10:   r_count <= r_count + LP_CNT_ONE;
                2'b01:   r_count <= r_count - LP_CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    // Flush FSM state register.
    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Flush sequencing: a request moves to FLUSH, which blocks new stores
    // while the queue keeps draining; once empty, DONE lasts one cycle to
    // produce the completion pulse. Requests outside RUN are ignored.
    always_comb begin
        w_state_next  = r_state;
        sb_flush_done = 1'b0;
        case (r_state)
            ST_RUN: begin
                if (SB_flush_req) begin
                    w_state_next = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                if (w_empty) begin
                    w_state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                sb_flush_done = 1'b1;
                w_state_next  = ST_RUN;
            end
            default: begin
                w_state_next = ST_RUN;
            end
        endcase
    end

    // Load conflict lookup on 8-byte granules. An entry being dequeued this
    // cycle is still valid here, and a store accepted this cycle is
    // matched directly from the enqueue inputs.
    always_comb begin
        w_entry_hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (r_valid[i] && (r_addr[i][31:3] == LD_check_addr[31:3])) begin
                w_entry_hit = 1'b1;
            end
        end
    end

    assign ld_conflict = LD_check_v &
                         (w_entry_hit |
                          (w_enq & (SB_enq_addr[31:3] == LD_check_addr[31:3])));

    // The byte offset within a granule plays no part in conflict detection.
    assign w_unused_low_bits = &{1'b0, LD_check_addr[2:0]};

    // Head presentation is zeroed when empty, so reset clears it at once.
    assign DC_write_req  = ~w_empty;
    assign DC_write_addr = w_empty ? 32'd0 : r_addr[r_head];
    assign DC_write_data = w_empty ? 64'd0 : r_data[r_head];
    assign DC_write_size = w_empty ? 2'd0  : r_size[r_head];

    assign sb_stall = SB_enq_v & (w_full | (r_state != ST_RUN));
    assign sb_empty = w_empty;

endmodule

// File: tb/tb_wb_store_buffer_ctrl.sv
// ---------------------------------------------------------------------------
// tb_wb_store_buffer_ctrl
//
// Directed bench for the store buffer controller. Inputs change one time
// unit after each rising edge and outputs are sampled on the falling edge,
// so every check sees the settled combinational view of the current cycle.
// ---------------------------------------------------------------------------
module tb_wb_store_buffer_ctrl;

    logic        CLK;
    logic        CLR;
    logic        SB_enq_v;
    logic [31:0] SB_enq_addr;
    logic [63:0] SB_enq_data;
    logic [1:0]  SB_enq_size;
    logic        In_write_ready;
    logic        LD_check_v;
    logic [31:0] LD_check_addr;
    logic        SB_flush_req;
    logic        DC_write_req;
    logic [31:0] DC_write_addr;
    logic [63:0] DC_write_data;
    logic [1:0]  DC_write_size;
    logic        sb_stall;
    logic        sb_empty;
    logic        ld_conflict;
    logic        sb_flush_done;

    int checkCount;
    int passCount;

    wb_store_buffer_ctrl #(.DEPTH(4), .PTR_W(2)) dut (
        .CLK            (CLK),
        .CLR            (CLR),
        .SB_enq_v       (SB_enq_v),
        .SB_enq_addr    (SB_enq_addr),
        .SB_enq_data    (SB_enq_data),
        .SB_enq_size    (SB_enq_size),
        .In_write_ready (In_write_ready),
        .LD_check_v     (LD_check_v),
        .LD_check_addr  (LD_check_addr),
        .SB_flush_req   (SB_flush_req),
        .DC_write_req   (DC_write_req),
        .DC_write_addr  (DC_write_addr),
        .DC_write_data  (DC_write_data),
        .DC_write_size  (DC_write_size),
        .sb_stall       (sb_stall),
        .sb_empty       (sb_empty),
        .ld_conflict    (ld_conflict),
        .sb_flush_done  (sb_flush_done)
    );

    // 10-unit clock period.
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checkCount++;
        if (observed === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Drives every DUT input for the coming cycle.
    task automatic applyStimulus(input logic enqV, input logic [31:0] addr,
                                 input logic [63:0] data, input logic [1:0] size,
                                 input logic ready, input logic ldV,
                                 input logic [31:0] ldAddr, input logic flush);
        SB_enq_v       = enqV;
        SB_enq_addr    = addr;
        SB_enq_data    = data;
        SB_enq_size    = size;
        In_write_ready = ready;
        LD_check_v     = ldV;
        LD_check_addr  = ldAddr;
        SB_flush_req   = flush;
    endtask

    task automatic idle(input logic ready);
        applyStimulus(1'b0, 32'd0, 64'd0, 2'd0, ready, 1'b0, 32'd0, 1'b0);
    endtask

    task automatic sampleEdge();
        @(negedge CLK);
    endtask

    task automatic nextCycle();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        checkCount = 0;
        passCount  = 0;
        CLR = 1'b1;
        idle(1'b0);

        // Test 1: reset values, then ten quiet cycles.
        #2;
        checkOutput("rst_req",   {63'd0, DC_write_req},  64'd0);
        checkOutput("rst_empty", {63'd0, sb_empty},      64'd1);
        checkOutput("rst_stall", {63'd0, sb_stall},      64'd0);
        checkOutput("rst_ldc",   {63'd0, ld_conflict},   64'd0);
        checkOutput("rst_done",  {63'd0, sb_flush_done}, 64'd0);
        checkOutput("rst_addr",  {32'd0, DC_write_addr}, 64'd0);
        nextCycle();
        CLR = 1'b0;
        for (int i = 0; i < 10; i++) begin
            sampleEdge();
            checkOutput("idle_empty", {63'd0, sb_empty},     64'd1);
            checkOutput("idle_req",   {63'd0, DC_write_req}, 64'd0);
            checkOutput("idle_stall", {63'd0, sb_stall},     64'd0);
            nextCycle();
        end

        // Test 2: single store, one-cycle visibility, then drained.
        applyStimulus(1'b1, 32'h1000, 64'hAA, 2'b10, 1'b1, 1'b0, 32'd0, 1'b0);
        sampleEdge();
        checkOutput("t2_req_c0",   {63'd0, DC_write_req}, 64'd0);
        checkOutput("t2_stall_c0", {63'd0, sb_stall},     64'd0);
        nextCycle();
        idle(1'b1);
        sampleEdge();
        checkOutput("t2_req",  {63'd0, DC_write_req},  64'd1);
        checkOutput("t2_addr", {32'd0, DC_write_addr}, 64'h1000);
        checkOutput("t2_data", DC_write_data,          64'hAA);
        checkOutput("t2_size", {62'd0, DC_write_size}, 64'd2);
        nextCycle();
        sampleEdge();
        checkOutput("t2_empty", {63'd0, sb_empty},     64'd1);
        checkOutput("t2_req_after", {63'd0, DC_write_req}, 64'd0);
        nextCycle();

        // Test 3: fill to DEPTH with ready low, fifth store stalls.
        for (int i = 1; i <= 4; i++) begin
            applyStimulus(1'b1, 32'(i * 32'h100), 64'(i * 64'h11), 2'(i - 1),
                          1'b0, 1'b0, 32'd0, 1'b0);
            sampleEdge();
            checkOutput("t3_fill_stall", {63'd0, sb_stall}, 64'd0);
            nextCycle();
        end
        applyStimulus(1'b1, 32'h500, 64'h55, 2'd3, 1'b0, 1'b0, 32'd0, 1'b0);
        sampleEdge();
        checkOutput("t3_full_stall", {63'd0, sb_stall},      64'd1);
        checkOutput("t3_head_addr",  {32'd0, DC_write_addr}, 64'h100);
        nextCycle();
        // Ready rises while still full: dequeue fires, enqueue still rejected.
        applyStimulus(1'b1, 32'h500, 64'h55, 2'd3, 1'b1, 1'b0, 32'd0, 1'b0);
        sampleEdge();
        checkOutput("t3_full_deq_stall", {63'd0, sb_stall},      64'd1);
        checkOutput("t3_drain1_addr",    {32'd0, DC_write_addr}, 64'h100);
        checkOutput("t3_drain1_data",    DC_write_data,          64'h11);
        nextCycle();
        sampleEdge();
        checkOutput("t3_accept_stall", {63'd0, sb_stall},      64'd0);
        checkOutput("t3_drain2_addr",  {32'd0, DC_write_addr}, 64'h200);
        nextCycle();
        idle(1'b1);
        sampleEdge();
        checkOutput("t3_drain3_addr", {32'd0, DC_write_addr}, 64'h300);
        checkOutput("t3_drain3_size", {62'd0, DC_write_size}, 64'd2);
        nextCycle();
        sampleEdge();
        checkOutput("t3_drain4_addr", {32'd0, DC_write_addr}, 64'h400);
        nextCycle();
        sampleEdge();
        checkOutput("t3_drain5_addr", {32'd0, DC_write_addr}, 64'h500);
        checkOutput("t3_drain5_data", DC_write_data,          64'h55);
        checkOutput("t3_drain5_req",  {63'd0, DC_write_req},  64'd1);
        nextCycle();
        sampleEdge();
        checkOutput("t3_empty", {63'd0, sb_empty}, 64'd1);
        nextCycle();

        // Test 4: load conflict detection on 8-byte granules.
        applyStimulus(1'b1, 32'h2004, 64'h24, 2'd1, 1'b0, 1'b0, 32'd0, 1'b0);
        nextCycle();
        applyStimulus(1'b0, 32'd0, 64'd0, 2'd0, 1'b0, 1'b1, 32'h2000, 1'b0);
        sampleEdge();
        checkOutput("t4_same_granule", {63'd0, ld_conflict}, 64'd1);
        nextCycle();
        applyStimulus(1'b0, 32'd0, 64'd0, 2'd0, 1'b0, 1'b1, 32'h2008, 1'b0);
        sampleEdge();
        checkOutput("t4_next_granule", {63'd0, ld_conflict}, 64'd0);
        nextCycle();
        applyStimulus(1'b0, 32'd0, 64'd0, 2'd0, 1'b0, 1'b0, 32'h2000, 1'b0);
        sampleEdge();
        checkOutput("t4_ld_invalid", {63'd0, ld_conflict}, 64'd0);
        nextCycle();
        applyStimulus(1'b1, 32'h3000, 64'h30, 2'd2, 1'b0, 1'b1, 32'h3007, 1'b0);
        sampleEdge();
        checkOutput("t4_same_cycle_enq", {63'd0, ld_conflict}, 64'd1);
        nextCycle();
        // Head 0x2004 is dequeued this cycle yet still conflicts.
        applyStimulus(1'b0, 32'd0, 64'd0, 2'd0, 1'b1, 1'b1, 32'h2000, 1'b0);
        sampleEdge();
        checkOutput("t4_deq_still_hits", {63'd0, ld_conflict}, 64'd1);
        nextCycle();
        applyStimulus(1'b0, 32'd0, 64'd0, 2'd0, 1'b1, 1'b1, 32'h2000, 1'b0);
        sampleEdge();
        checkOutput("t4_after_deq", {63'd0, ld_conflict}, 64'd0);
        nextCycle();
        idle(1'b0);
        sampleEdge();
        checkOutput("t4_empty", {63'd0, sb_empty}, 64'd1);
        nextCycle();

        // Test 5: flush with three pending stores.
        for (int i = 1; i <= 3; i++) begin
            applyStimulus(1'b1, 32'(32'h4000 + i * 8), 64'(i), 2'd2,
                          1'b0, 1'b0, 32'd0, 1'b0);
            nextCycle();
        end
        applyStimulus(1'b0, 32'd0, 64'd0, 2'd0, 1'b0, 1'b0, 32'd0, 1'b1);
        nextCycle();
        applyStimulus(1'b1, 32'h5000, 64'h50, 2'd0, 1'b0, 1'b0, 32'd0, 1'b0);
        sampleEdge();
        checkOutput("t5_flush_stall", {63'd0, sb_stall}, 64'd1);
        nextCycle();
        applyStimulus(1'b1, 32'h5000, 64'h50, 2'd0, 1'b1, 1'b0, 32'd0, 1'b0);
        for (int i = 1; i <= 3; i++) begin
            sampleEdge();
            checkOutput("t5_drain_addr",  {32'd0, DC_write_addr}, 64'(32'h4000 + i * 8));
            checkOutput("t5_drain_stall", {63'd0, sb_stall},      64'd1);
            nextCycle();
        end
        sampleEdge();
        checkOutput("t5_flush_empty",   {63'd0, sb_empty},      64'd1);
        checkOutput("t5_done_early",    {63'd0, sb_flush_done}, 64'd0);
        checkOutput("t5_stall_empty",   {63'd0, sb_stall},      64'd1);
        nextCycle();
        sampleEdge();
        checkOutput("t5_done",          {63'd0, sb_flush_done}, 64'd1);
        checkOutput("t5_done_stall",    {63'd0, sb_stall},      64'd1);
        nextCycle();
        sampleEdge();
        checkOutput("t5_run_done",      {63'd0, sb_flush_done}, 64'd0);
        checkOutput("t5_run_stall",     {63'd0, sb_stall},      64'd0);
        nextCycle();
        idle(1'b0);
        sampleEdge();
        checkOutput("t5_accepted_req",  {63'd0, DC_write_req},  64'd1);
        checkOutput("t5_accepted_addr", {32'd0, DC_write_addr}, 64'h5000);
        nextCycle();
        idle(1'b1);
        nextCycle();

        // Flush request while empty: done pulse two cycles after the request.
        applyStimulus(1'b0, 32'd0, 64'd0, 2'd0, 1'b0, 1'b0, 32'd0, 1'b1);
        sampleEdge();
        checkOutput("t5e_done_c0", {63'd0, sb_flush_done}, 64'd0);
        nextCycle();
        idle(1'b0);
        sampleEdge();
        checkOutput("t5e_done_c1", {63'd0, sb_flush_done}, 64'd0);
        nextCycle();
        sampleEdge();
        checkOutput("t5e_done_c2", {63'd0, sb_flush_done}, 64'd1);
        nextCycle();
        sampleEdge();
        checkOutput("t5e_done_c3", {63'd0, sb_flush_done}, 64'd0);
        nextCycle();

        // Test 6: asynchronous reset in the middle of a drain.
        for (int i = 1; i <= 2; i++) begin
            applyStimulus(1'b1, 32'(32'h6000 + i * 16), 64'(i), 2'd1,
                          1'b0, 1'b0, 32'd0, 1'b0);
            nextCycle();
        end
        idle(1'b1);
        sampleEdge();
        checkOutput("t6_pre_req", {63'd0, DC_write_req}, 64'd1);
        nextCycle();
        #2;
        CLR = 1'b1;
        #1;
        checkOutput("t6_clr_req",   {63'd0, DC_write_req},  64'd0);
        checkOutput("t6_clr_empty", {63'd0, sb_empty},      64'd1);
        checkOutput("t6_clr_addr",  {32'd0, DC_write_addr}, 64'd0);
        checkOutput("t6_clr_data",  DC_write_data,          64'd0);
        nextCycle();
        CLR = 1'b0;
        for (int i = 0; i < 2; i++) begin
            sampleEdge();
            checkOutput("t6_post_req", {63'd0, DC_write_req}, 64'd0);
            nextCycle();
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
